sint_cmp_pipe: RTL and testbench



---
 rtl/sint_cmp_pipe_if.sv | 29 ++
 rtl/sint_cmp_pipe.sv | 105 ++++++++++
 tb/tb_sint_cmp_pipe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sint_cmp_pipe_if.sv
// Operand/result handshake bundle for sint_cmp_pipe.
// The master side drives operands and result backpressure; the slave side is the comparator pipeline.
interface sint_cmp_pipe_if #(
  parameter int WIDTH       = 3,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       I0;
  logic [WIDTH-1:0]       I1;
  logic [2:0]             op;
  logic                   is_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic                   O;
  logic                   err;
  logic                   clear_count;
  logic [COUNT_WIDTH-1:0] true_count;

  modport master (
    output in_valid, I0, I1, op, is_signed, out_ready, clear_count,
    input  in_ready, out_valid, O, err, true_count
  );

  modport slave (
    input  in_valid, I0, I1, op, is_signed, out_ready, clear_count,
    output in_ready, out_valid, O, err, true_count
  );
endinterface

// File: rtl/sint_cmp_pipe.sv
// Pipelined signed/unsigned comparator with a runtime-selected relation,
// valid/ready backpressure and a saturating count of delivered true results.
module sint_cmp_pipe #(
  parameter int WIDTH       = 3,
  parameter int STAGES      = 2,
  parameter int COUNT_WIDTH = 16
) (
  input logic             CLK,
  input logic             ASYNCRESETN,
  sint_cmp_pipe_if.slave  bus
);

  localparam logic [2:0] OP_GT = 3'd0;
  localparam logic [2:0] OP_GE = 3'd1;
  localparam logic [2:0] OP_LT = 3'd2;
  localparam logic [2:0] OP_LE = 3'd3;
  localparam logic [2:0] OP_EQ = 3'd4;
  localparam logic [2:0] OP_NE = 3'd5;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             lt;
  logic             eq;
  logic             res;
  logic             res_err;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] o_q,   o_d;
  logic [STAGES-1:0] err_q, err_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic stall;
  logic out_xfer;

  assign opa = bus.I0;
  assign opb = bus.I1;

  // Every relation is derived from one less-than and one equality.
  always_comb begin
    eq      = (opa == opb);
    lt      = bus.is_signed ? ($signed(opa) < $signed(opb)) : (opa < opb);
    res     = 1'b0;
    res_err = 1'b0;
    case (bus.op)
      OP_GT:   res = ~lt & ~eq;
      OP_GE:   res = ~lt;
      OP_LT:   res = lt;
      OP_LE:   res = lt | eq;
      OP_EQ:   res = eq;
      OP_NE:   res = ~eq;
      default: res_err = 1'b1;
    endcase
  end

  // Whole pipeline holds on output stall; bubbles are shifted, never squeezed out.
  always_comb begin
    stall = vld_q[STAGES-1] & ~bus.out_ready;
    vld_d = vld_q;
    o_d   = o_q;
    err_d = err_q;
    if (!stall) begin
      vld_d[0] = bus.in_valid;
      o_d[0]   = res;
      err_d[0] = res_err;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        o_d[i]   = o_q[i-1];
        err_d[i] = err_q[i-1];
      end
    end
  end

  // Clear wins over a same-edge increment.
  always_comb begin
    out_xfer = vld_q[STAGES-1] & bus.out_ready;
    cnt_d    = cnt_q;
    if (bus.clear_count) begin
      cnt_d = '0;
    end else if (out_xfer && o_q[STAGES-1] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      vld_q <= '0;
      o_q   <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      o_q   <= o_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready   = ~stall;
  assign bus.out_valid  = vld_q[STAGES-1];
  assign bus.O          = o_q[STAGES-1];
  assign bus.err        = err_q[STAGES-1];
  assign bus.true_count = cnt_q;

endmodule

// File: tb/tb_sint_cmp_pipe.sv
// Self-checking bench for sint_cmp_pipe: an arithmetic reference model with a transfer
// scoreboard checked every cycle, plus directed vectors with hand-computed results.
module tb_sint_cmp_pipe;

  localparam int WIDTH       = 3;
  localparam int STAGES      = 2;
  localparam int COUNT_WIDTH = 2;
  localparam int CNT_MAX     = (1 << COUNT_WIDTH) - 1;

  logic CLK = 1'b0;
  logic ASYNCRESETN;

  sint_cmp_pipe_if #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) bus ();

  sint_cmp_pipe #(
    .WIDTH(WIDTH),
    .STAGES(STAGES),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .CLK(CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit o;
    bit err;
    int edge_no;
    int snap;
  } exp_t;

  exp_t q[$];
  int dir_tests = 0;
  int dir_fails = 0;
  int mon_tests = 0;
  int mon_fails = 0;
  int rst_pulses = 0;
  int seen_pulses = 0;
  int edge_idx = 0;
  int stall_total = 0;
  int exp_cnt = 0;
  bit front_seen = 1'b0;

  function automatic int toInt(input logic [WIDTH-1:0] v, input bit sgn);
    int x;
    x = int'(v);
    if (sgn && x >= (1 << (WIDTH - 1))) x = x - (1 << WIDTH);
    return x;
  endfunction

  // Returns {err, O} from integer relations on the interpreted operand values.
  function automatic logic [1:0] modelCompare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] op, input bit sgn);
    int x;
    int y;
    x = toInt(a, sgn);
    y = toInt(b, sgn);
    case (op)
      3'd0:    return {1'b0, x >  y};
      3'd1:    return {1'b0, x >= y};
      3'd2:    return {1'b0, x <  y};
      3'd3:    return {1'b0, x <= y};
      3'd4:    return {1'b0, x == y};
      3'd5:    return {1'b0, x != y};
      default: return 2'b10;
    endcase
  endfunction

  task automatic monCheck(input string name, input int got, input int exp);
    mon_tests++;
    if (got !== exp) begin
      mon_fails++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, edge_idx, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    dir_tests++;
    if (got !== exp) begin
      dir_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] o, input bit s, input bit rdy, input bit clr);
    bus.in_valid    = v;
    bus.I0          = a;
    bus.I1          = b;
    bus.op          = o;
    bus.is_signed   = s;
    bus.out_ready   = rdy;
    bus.clear_count = clr;
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: inputs are stable at the falling edge, so transfers for the next rising edge are decided here.
  exp_t f;
  int req;
  int elapsed;
  logic [1:0] r;
  always @(negedge CLK) begin
    if (ASYNCRESETN) begin
      if (rst_pulses != seen_pulses) begin
        q.delete();
        exp_cnt     = 0;
        front_seen  = 1'b0;
        seen_pulses = rst_pulses;
      end
      monCheck("true_count", int'(bus.true_count), exp_cnt);
      monCheck("in_ready", int'(bus.in_ready), (bus.out_valid && !bus.out_ready) ? 0 : 1);
      if (q.size() > 0 && !front_seen) begin
        f       = q[0];
        req     = STAGES - 1 + stall_total - f.snap;
        elapsed = edge_idx - 1 - f.edge_no;
        if (bus.out_valid) begin
          monCheck("latency", elapsed, req);
          front_seen = 1'b1;
        end else if (elapsed >= req) begin
          monCheck("lost_result", int'(bus.out_valid), 1);
          front_seen = 1'b1;
        end
      end
      if (bus.out_valid) begin
        monCheck("valid_has_pending", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          monCheck("O", int'(bus.O), int'(q[0].o));
          monCheck("err", int'(bus.err), int'(q[0].err));
        end
      end
      if (bus.out_valid && !bus.out_ready) stall_total++;
      if (bus.clear_count) exp_cnt = 0;
      else if (bus.out_valid && bus.out_ready && q.size() > 0 && q[0].o && exp_cnt < CNT_MAX)
        exp_cnt++;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        void'(q.pop_front());
        front_seen = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        r = modelCompare(bus.I0, bus.I1, bus.op, bus.is_signed);
        q.push_back('{o: r[0], err: r[1], edge_no: edge_idx, snap: stall_total});
      end
    end
    edge_idx++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sweep_o [6];
    sweep_o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    ASYNCRESETN     = 1'b0;
    bus.in_valid    = 1'b0;
    bus.I0          = '0;
    bus.I1          = '0;
    bus.op          = 3'd0;
    bus.is_signed   = 1'b0;
    bus.out_ready   = 1'b1;
    bus.clear_count = 1'b0;

    #7;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_O", bus.O, 0);
    checkOutput("reset_err", bus.err, 0);
    checkOutput("reset_true_count", bus.true_count, 0);
    #5 ASYNCRESETN = 1'b1;
    #1 checkOutput("in_ready_after_reset", bus.in_ready, 1);
    @(posedge CLK);
    #1;

    // Signedness: 3 > -3 is true, 3 > 5 is false.
    applyStimulus(1, 3'b011, 3'b101, 3'd0, 1, 1, 0);
    checkOutput("latency_not_early", bus.out_valid, 0);
    applyStimulus(1, 3'b011, 3'b101, 3'd0, 0, 1, 0);
    checkOutput("sgt_valid", bus.out_valid, 1);
    checkOutput("sgt_signed_O", bus.O, 1);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("ugt_valid", bus.out_valid, 1);
    checkOutput("ugt_unsigned_O", bus.O, 0);

    // Relation sweep on equal operands, then a reserved op.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 3'b100, 3'b100, 3'(i), 1, 1, 0);
      if (i > 0) begin
        checkOutput($sformatf("sweep_valid_op%0d", i - 1), bus.out_valid, 1);
        checkOutput($sformatf("sweep_O_op%0d", i - 1), bus.O, int'(sweep_o[i-1]));
        checkOutput($sformatf("sweep_err_op%0d", i - 1), bus.err, 0);
      end
    end
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("reserved_O", bus.O, 0);
    checkOutput("reserved_err", bus.err, 1);
    checkOutput("count_saturated_sweep", bus.true_count, 3);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("bubble_valid", bus.out_valid, 0);

    // Backpressure with extreme operands.
    applyStimulus(1, 3'b100, 3'b011, 3'd2, 1, 1, 0);
    applyStimulus(1, 3'b111, 3'b000, 3'd0, 1, 1, 0);
    checkOutput("bp_lt_extreme_O", bus.O, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'b111, 3'b000, 3'd0, 0, 0, 0);
      checkOutput($sformatf("stall%0d_in_ready", i), bus.in_ready, 0);
      checkOutput($sformatf("stall%0d_valid", i), bus.out_valid, 1);
      checkOutput($sformatf("stall%0d_O", i), bus.O, 1);
    end
    applyStimulus(1, 3'b111, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("bp_gt_extreme_valid", bus.out_valid, 1);
    checkOutput("bp_gt_extreme_O", bus.O, 0);
    applyStimulus(1, 3'b010, 3'b010, 3'd5, 0, 1, 0);
    checkOutput("bp_third_O", bus.O, 1);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("bp_fourth_valid", bus.out_valid, 1);
    checkOutput("bp_fourth_O", bus.O, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("bp_drained_valid", bus.out_valid, 0);

    // Counter saturation and clear priority.
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 1);
    checkOutput("clear_count", bus.true_count, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 3'b000, 3'b000, 3'd4, 0, 1, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("count_saturated", bus.true_count, 3);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("count_holds", bus.true_count, 3);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 1);
    checkOutput("clear_again", bus.true_count, 0);
    applyStimulus(1, 3'b000, 3'b000, 3'd4, 0, 1, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("count_one", bus.true_count, 1);
    applyStimulus(1, 3'b000, 3'b000, 3'd4, 0, 1, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("pre_clear_valid", bus.out_valid, 1);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 1);
    checkOutput("clear_priority", bus.true_count, 0);

    // Reset mid-flight.
    applyStimulus(1, 3'b000, 3'b000, 3'd4, 0, 1, 0);
    applyStimulus(1, 3'b011, 3'b001, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("pre_reset_count", bus.true_count, 1);
    checkOutput("pre_reset_valid", bus.out_valid, 1);
    ASYNCRESETN = 1'b0;
    rst_pulses++;
    #1;
    checkOutput("async_reset_valid", bus.out_valid, 0);
    checkOutput("async_reset_count", bus.true_count, 0);
    #1 ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("no_stale_result", bus.out_valid, 0);
    applyStimulus(1, 3'b011, 3'b001, 3'd0, 0, 1, 0);
    checkOutput("post_reset_not_early", bus.out_valid, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("post_reset_valid", bus.out_valid, 1);
    checkOutput("post_reset_O", bus.O, 1);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    applyStimulus(0, 3'b000, 3'b000, 3'd0, 0, 1, 0);
    checkOutput("final_valid", bus.out_valid, 0);
    checkOutput("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", dir_tests + mon_tests, dir_fails + mon_fails);
    $finish;
  end

endmodule
